// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - 8051 stack sequencer: SP ownership, push/pop/call/ret byte sequencing
module stack_ctrl #(
  parameter logic [7:0] RST_SP      = 8'h07,
  parameter logic [7:0] SFR_SP_ADDR = 8'h81
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [1:0]  instr_op,
  input  logic [7:0]  push_data,
  input  logic [15:0] pc_in,
  input  logic        int_req,
  input  logic [15:0] int_pc,
  input  logic        wr,
  input  logic        wr_bit,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [7:0]  ram_rdata,
  output logic        instr_ack,
  output logic        int_ack,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        ram_re,
  output logic [7:0]  sp,
  output logic [7:0]  pop_data,
  output logic [15:0] pc_out
);

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_CALL = 2'd2;
  localparam logic [1:0] OP_RET  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_R0, S_C0, S_C1} state_t;

  state_t      r_state;
  logic [7:0]  r_sp;
  logic [1:0]  r_op;
  logic [7:0]  r_lo_data;
  logic [7:0]  r_hi_data;
  logic        r_pend_valid;
  logic [7:0]  r_pend_data;
  logic [7:0]  r_pop_data;
  logic [15:0] r_pc_out;

  logic       w_idle;
  logic       w_sfr_hit;
  logic       w_accept_int;
  logic       w_accept_instr;
  logic       w_instr_is_read;
  logic [7:0] w_sp_inc;
  logic [7:0] w_sp_dec;

  assign w_idle          = (r_state == S_IDLE);
  assign w_sfr_hit       = wr & ~wr_bit & (wr_addr == SFR_SP_ADDR);
  // Any SP write landing in IDLE (direct or deferred) consumes that cycle.
  assign w_accept_int    = w_idle & ~reset & ~w_sfr_hit & ~r_pend_valid & int_req;
  assign w_accept_instr  = w_idle & ~reset & ~w_sfr_hit & ~r_pend_valid & ~int_req & instr_req;
  assign w_instr_is_read = (instr_op == OP_POP) | (instr_op == OP_RET);
  assign w_sp_inc        = r_sp + 8'd1;
  assign w_sp_dec        = r_sp - 8'd1;

  assign instr_ack = w_accept_instr;
  assign int_ack   = w_accept_int;
  assign busy      = ~w_idle;
  assign sp        = r_sp;
  assign ram_we    = (r_state == S_W0) | (r_state == S_W1);
  assign ram_re    = (r_state == S_R0) | ((r_state == S_C0) & (r_op == OP_RET));
  assign ram_addr  = ram_we ? w_sp_inc : r_sp;
  assign ram_wdata = (r_state == S_W1) ? r_hi_data : r_lo_data;
  assign done      = ((r_state == S_W0) & (r_op == OP_PUSH)) | (r_state == S_W1) |
                     ((r_state == S_C0) & (r_op == OP_POP))  | (r_state == S_C1);
  // Read data is forwarded so the result is visible in the done cycle.
  assign pop_data  = ((r_state == S_C0) & (r_op == OP_POP)) ? ram_rdata : r_pop_data;
  assign pc_out    = (r_state == S_C1) ? {r_pc_out[15:8], ram_rdata} : r_pc_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sp         <= RST_SP;
      r_op         <= OP_PUSH;
      r_lo_data    <= 8'h00;
      r_hi_data    <= 8'h00;
      r_pend_valid <= 1'b0;
      r_pend_data  <= 8'h00;
      r_pop_data   <= 8'h00;
      r_pc_out     <= 16'h0000;
    end else begin
      if (!w_idle && w_sfr_hit) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= wr_data;
      end
      case (r_state)
        S_IDLE: begin
          if (w_sfr_hit) begin
            r_sp         <= wr_data;
            r_pend_valid <= 1'b0;
          end else if (r_pend_valid) begin
            r_sp         <= r_pend_data;
            r_pend_valid <= 1'b0;
          end else if (w_accept_int) begin
            r_op      <= OP_CALL;
            r_lo_data <= int_pc[7:0];
            r_hi_data <= int_pc[15:8];
            r_state   <= S_W0;
          end else if (w_accept_instr) begin
            r_op      <= instr_op;
            r_lo_data <= (instr_op == OP_PUSH) ? push_data : pc_in[7:0];
            r_hi_data <= pc_in[15:8];
            r_state   <= w_instr_is_read ? S_R0 : S_W0;
          end
        end
        S_W0: begin
          r_sp    <= w_sp_inc;
          r_state <= (r_op == OP_PUSH) ? S_IDLE : S_W1;
        end
        S_W1: begin
          r_sp    <= w_sp_inc;
          r_state <= S_IDLE;
        end
        S_R0: begin
          r_sp    <= w_sp_dec;
          r_state <= S_C0;
        end
        S_C0: begin
          if (r_op == OP_POP) begin
            r_pop_data <= ram_rdata;
            r_state    <= S_IDLE;
          end else begin
            r_pc_out[15:8] <= ram_rdata;
            r_sp           <= w_sp_dec;
            r_state        <= S_C1;
          end
        end
        S_C1: begin
          r_pc_out[7:0] <= ram_rdata;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl
module tb_stack_ctrl;

  logic        clock;
  logic        reset;
  logic        instr_req;
  logic [1:0]  instr_op;
  logic [7:0]  push_data;
  logic [15:0] pc_in;
  logic        int_req;
  logic [15:0] int_pc;
  logic        wr;
  logic        wr_bit;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  ram_rdata;
  logic        instr_ack;
  logic        int_ack;
  logic        busy;
  logic        done;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [7:0]  sp;
  logic [7:0]  pop_data;
  logic [15:0] pc_out;

  logic [7:0]  mem [256];
  int          n_checks;
  int          n_errors;

  stack_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .instr_req (instr_req),
    .instr_op  (instr_op),
    .push_data (push_data),
    .pc_in     (pc_in),
    .int_req   (int_req),
    .int_pc    (int_pc),
    .wr        (wr),
    .wr_bit    (wr_bit),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ram_rdata (ram_rdata),
    .instr_ack (instr_ack),
    .int_ack   (int_ack),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .sp        (sp),
    .pop_data  (pop_data),
    .pc_out    (pc_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Internal data RAM: synchronous write, one-cycle read latency.
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] addr, input logic [7:0] data);
    check({tag, "_we"}, {31'd0, ram_we}, 32'd1);
    check({tag, "_re"}, {31'd0, ram_re}, 32'd0);
    check({tag, "_addr"}, {24'd0, ram_addr}, {24'd0, addr});
    check({tag, "_wdata"}, {24'd0, ram_wdata}, {24'd0, data});
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] addr);
    check({tag, "_re"}, {31'd0, ram_re}, 32'd1);
    check({tag, "_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_addr"}, {24'd0, ram_addr}, {24'd0, addr});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    ram_rdata = 8'h00;
    reset = 1'b1; instr_req = 1'b0; instr_op = 2'd0; push_data = 8'h00; pc_in = 16'h0;
    int_req = 1'b0; int_pc = 16'h0; wr = 1'b0; wr_bit = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    tick(); tick();
    check("rst_sp", {24'd0, sp}, 32'h07);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_strobes", {30'd0, ram_we, ram_re}, 32'd0);
    check("rst_pop", {24'd0, pop_data}, 32'd0);
    check("rst_pc", {16'd0, pc_out}, 32'd0);
    reset = 1'b0;

    // PUSH 0xA5 from SP=0x07
    instr_req = 1'b1; instr_op = 2'd0; push_data = 8'hA5; settle();
    check("push_ack", {31'd0, instr_ack}, 32'd1);
    check("push_busy0", {31'd0, busy}, 32'd0);
    tick(); instr_req = 1'b0; push_data = 8'hFF; settle();
    chk_wr("push_w0", 8'h08, 8'hA5);
    check("push_done", {31'd0, done}, 32'd1);
    check("push_busy1", {31'd0, busy}, 32'd1);
    tick();
    check("push_sp", {24'd0, sp}, 32'h08);
    check("push_idle", {31'd0, busy}, 32'd0);

    // SFR write SP=0x07 blocks a held CALL for one cycle
    wr = 1'b1; wr_addr = 8'h81; wr_data = 8'h07;
    instr_req = 1'b1; instr_op = 2'd2; pc_in = 16'h1234; settle();
    check("sfr_block_ack", {31'd0, instr_ack}, 32'd0);
    tick(); wr = 1'b0; settle();
    check("sfr_sp", {24'd0, sp}, 32'h07);
    check("call_ack", {31'd0, instr_ack}, 32'd1);
    tick(); instr_req = 1'b0; pc_in = 16'h0; settle();
    chk_wr("call_w0", 8'h08, 8'h34);
    check("call_w0_done", {31'd0, done}, 32'd0);
    tick();
    chk_wr("call_w1", 8'h09, 8'h12);
    check("call_w1_done", {31'd0, done}, 32'd1);
    tick();
    check("call_sp", {24'd0, sp}, 32'h09);

    // RET returns 0x1234
    instr_req = 1'b1; instr_op = 2'd3; settle();
    check("ret_ack", {31'd0, instr_ack}, 32'd1);
    tick(); instr_req = 1'b0; settle();
    chk_rd("ret_r0", 8'h09);
    tick();
    chk_rd("ret_c0", 8'h08);
    check("ret_c0_done", {31'd0, done}, 32'd0);
    tick();
    check("ret_c1_done", {31'd0, done}, 32'd1);
    check("ret_c1_pc", {16'd0, pc_out}, 32'h1234);
    check("ret_c1_re", {31'd0, ram_re}, 32'd0);
    tick();
    check("ret_sp", {24'd0, sp}, 32'h07);
    check("ret_pc_hold", {16'd0, pc_out}, 32'h1234);

    // Simultaneous POP and interrupt: interrupt wins
    instr_req = 1'b1; instr_op = 2'd1; int_req = 1'b1; int_pc = 16'hABCD; settle();
    check("arb_int_ack", {31'd0, int_ack}, 32'd1);
    check("arb_instr_ack", {31'd0, instr_ack}, 32'd0);
    tick(); int_req = 1'b0; int_pc = 16'h0; settle();
    chk_wr("int_w0", 8'h08, 8'hCD);
    check("int_w0_iack", {31'd0, instr_ack}, 32'd0);
    tick();
    chk_wr("int_w1", 8'h09, 8'hAB);
    check("int_w1_done", {31'd0, done}, 32'd1);
    tick();
    check("pop_ack_late", {31'd0, instr_ack}, 32'd1);
    check("int_sp", {24'd0, sp}, 32'h09);
    tick(); instr_req = 1'b0; settle();
    chk_rd("pop_r0", 8'h09);
    tick();
    check("pop_done", {31'd0, done}, 32'd1);
    check("pop_data", {24'd0, pop_data}, 32'hAB);
    tick();
    check("pop_sp", {24'd0, sp}, 32'h08);
    check("pop_hold", {24'd0, pop_data}, 32'hAB);

    // SFR write during CALL W0 is deferred to the first IDLE cycle
    instr_req = 1'b1; instr_op = 2'd2; pc_in = 16'h5678; settle();
    check("pend_call_ack", {31'd0, instr_ack}, 32'd1);
    tick(); instr_req = 1'b0; wr = 1'b1; wr_addr = 8'h81; wr_data = 8'h30; settle();
    chk_wr("pend_w0", 8'h09, 8'h78);
    tick(); wr = 1'b0; instr_req = 1'b1; instr_op = 2'd0; push_data = 8'h11; settle();
    chk_wr("pend_w1", 8'h0A, 8'h56);
    tick();
    check("pend_idle_busy", {31'd0, busy}, 32'd0);
    check("pend_idle_ack", {31'd0, instr_ack}, 32'd0);
    tick();
    check("pend_sp", {24'd0, sp}, 32'h30);
    check("pend_late_ack", {31'd0, instr_ack}, 32'd1);
    tick(); instr_req = 1'b0; settle();
    chk_wr("pend_push", 8'h31, 8'h11);
    tick();
    check("pend_push_sp", {24'd0, sp}, 32'h31);

    // Wrap: SP=0xFF, PUSH, POP, POP
    wr = 1'b1; wr_addr = 8'h81; wr_data = 8'hFF;
    tick(); wr = 1'b0; instr_req = 1'b1; instr_op = 2'd0; push_data = 8'h5A; settle();
    check("wrap_sp_ff", {24'd0, sp}, 32'hFF);
    check("wrap_push_ack", {31'd0, instr_ack}, 32'd1);
    tick(); instr_req = 1'b0; settle();
    chk_wr("wrap_push", 8'h00, 8'h5A);
    tick(); instr_req = 1'b1; instr_op = 2'd1; settle();
    check("wrap_sp_00", {24'd0, sp}, 32'h00);
    tick(); instr_req = 1'b0; settle();
    chk_rd("wrap_pop1", 8'h00);
    tick();
    check("wrap_pop1_data", {24'd0, pop_data}, 32'h5A);
    tick(); instr_req = 1'b1; settle();
    check("wrap_sp_ff2", {24'd0, sp}, 32'hFF);
    tick(); instr_req = 1'b0; settle();
    chk_rd("wrap_pop2", 8'hFF);
    tick();
    check("wrap_pop2_data", {24'd0, pop_data}, 32'hC3);
    tick();
    check("wrap_sp_fe", {24'd0, sp}, 32'hFE);

    // Reset during RET C0 aborts the sequence
    instr_req = 1'b1; instr_op = 2'd3; settle();
    check("abort_ack", {31'd0, instr_ack}, 32'd1);
    tick(); instr_req = 1'b0; settle();
    chk_rd("abort_r0", 8'hFE);
    tick(); reset = 1'b1; settle();
    chk_rd("abort_c0", 8'hFD);
    tick(); reset = 1'b0; settle();
    check("abort_sp", {24'd0, sp}, 32'h07);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_pc", {16'd0, pc_out}, 32'd0);
    check("abort_re", {31'd0, ram_re}, 32'd0);
    check("abort_pop", {24'd0, pop_data}, 32'd0);
    instr_req = 1'b1; instr_op = 2'd0; push_data = 8'h77; settle();
    check("post_ack", {31'd0, instr_ack}, 32'd1);
    tick(); instr_req = 1'b0; settle();
    chk_wr("post_push", 8'h08, 8'h77);
    check("post_done", {31'd0, done}, 32'd1);
    tick();
    check("post_sp", {24'd0, sp}, 32'h08);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Stack sequencer for the 8051 core. Owns the stack pointer and turns single-cycle stack requests from the instruction decoder (PUSH, POP, LCALL/ACALL, RET/RETI) and the interrupt controller (vector entry) into correctly ordered byte accesses on the internal data RAM port. It arbitrates between the two requesters and merges SFR writes to SP (address 0x81). It also returns popped bytes and return addresses to the core.

## Interface
Parameters
- RST_SP, 8'h07, SP value after reset
- SFR_SP_ADDR, 8'h81, SFR address of SP

Ports
- clock  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- instr_req  in  1  decoder request; held until instr_ack
- instr_op  in  2  0=PUSH, 1=POP, 2=CALL, 3=RET
- push_data  in  8  byte for PUSH
- pc_in  in  16  return address for CALL
- int_req  in  1  interrupt vector entry request; held until int_ack
- int_pc  in  16  return address for interrupt entry
- wr  in  1  SFR write strobe
- wr_bit  in  1  bit-addressed write qualifier
- wr_addr  in  8  SFR write address
- wr_data  in  8  SFR write data
- ram_rdata  in  8  RAM read data, valid the cycle after ram_re
- instr_ack  out  1  one-cycle pulse: instr request accepted
- int_ack  out  1  one-cycle pulse: interrupt request accepted
- busy  out  1  sequence in progress (state != IDLE)
- done  out  1  one-cycle pulse on the final cycle of a sequence
- ram_addr  out  8  RAM address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe
- sp  out  8  current stack pointer
- pop_data  out  8  last POP byte; held until next POP
- pc_out  out  16  last RET address; held until next RET

## Operation
- Reset value: sp=RST_SP. pop_data=0 and pc_out=0. All strobes, acks, busy and done=0. State=IDLE. Pending SFR write is cleared.
- Push is pre-increment: write at SP+1, then SP←SP+1. Pop is post-decrement: read at SP, then SP←SP−1.
- SP arithmetic is modulo 256. 0xFF+1=0x00 and 0x00−1=0xFF. There is no underflow guard.
- SFR write hit: wr & !wr_bit & wr_addr==SFR_SP_ADDR.
  - In IDLE, SP←wr_data and no request is accepted that cycle.
  - While busy, the value is latched into a pending register; a later hit overwrites it. It is applied in the first IDLE cycle, and no request is accepted that cycle.
- Arbitration in IDLE (no SFR hit or pending write): int_req wins over instr_req. The loser stays unacknowledged.
- States and transitions:
  - IDLE→W0 for PUSH, CALL or interrupt.
  - IDLE→R0 for POP or RET.
  - W0: write low byte (PUSH: push_data; CALL/int: PC[7:0]) at SP+1; SP←SP+1. Single-byte→IDLE with done; two-byte→W1.
  - W1: write PC[15:8] at SP+1; SP←SP+1; done; →IDLE.
  - R0: ram_re, addr=SP; SP←SP−1; →C0.
  - C0: capture ram_rdata. For POP: pop_data←ram_rdata, done, →IDLE. For RET: pc_out[15:8]←ram_rdata, ram_re addr=SP, SP←SP−1, →C1.
  - C1: pc_out[7:0]←ram_rdata; done; →IDLE.
- Operands (push_data, pc_in/int_pc, op) are latched on acceptance. Later input changes have no effect.
- Reset mid-sequence aborts immediately. The next cycle shows reset values, and no further RAM strobes are issued.

## Timing
- Request accepted in cycle N: ack pulses in N, and busy=1 from N+1.
- PUSH: write in N+1; done in N+1.
- CALL/int: writes in N+1 and N+2; done in N+2.
- POP: read in N+1; pop_data valid and done in N+2.
- RET: reads in N+1 and N+2; pc_out valid and done in N+3.
- busy falls in the cycle after done. A new request can be accepted in that cycle, giving one idle cycle minimum between sequences.
- sp output reflects the registered SP, updated at the end of each W/R cycle.
- ram_we and ram_re are never high together.
- ram_addr/ram_wdata are don't-care when no strobe is active.

## Test plan
- Reset, PUSH 0xA5 → write addr 0x08 data 0xA5 at N+1; sp=0x08; done at N+1.
- CALL pc_in=0x1234 from SP=0x07 → writes (0x08,0x34), (0x09,0x12); sp=0x09. Then RET returns pc_out=0x1234, sp=0x07, done at N+3.
- instr_req(POP) and int_req in the same IDLE cycle → int_ack first, stack writes for int_pc; instr_ack one cycle after int done.
- SP SFR write 0x30 during CALL W0 → pending; sp=0x30 in the first IDLE cycle. A request held that cycle is acked the cycle after.
- Wrap: SP=0xFF, PUSH → write at 0x00, sp=0x00. Then POP twice → reads 0x00, then 0xFF; sp=0xFE.
- reset asserted during RET C0 → next cycle sp=0x07, busy=0, pc_out=0, no ram_re; then PUSH behaves as after power-up.
